// File: rtl/mem_bus_arbiter.sv
// N-master arbiter for the shared console memory bus: fixed or round-robin, bus lock, read return.
// Optional per-master grant counters are built when ARB_GRANT_COUNT_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        lock,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [NUM_MASTERS*16-1:0]     grant_count
);

  localparam int unsigned IDW = $clog2(NUM_MASTERS);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_MASTERS - 1);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic           owner_valid;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           accept;

  logic [RD_LATENCY:0]          rd_vld;
  logic [RD_LATENCY:0][IDW-1:0] rd_id;

  always_comb begin
    gnt    = '0;
    win_id = '0;
    accept = 1'b0;
    idx    = ptr;
    if (owner_valid) begin
      // A held lock shuts out everyone else, even while the owner is idle.
      if (req[owner]) begin
        win_id = owner;
        accept = 1'b1;
      end
    end else if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_id = IDW'(i);
          accept = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!accept && req[idx]) begin
          win_id = idx;
          accept = 1'b1;
        end
        idx = (idx == LAST) ? '0 : idx + 1'b1;
      end
    end
    if (accept) gnt[win_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      rd_vld      <= '0;
      rd_id       <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        mem_addr  <= addr[win_id*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[win_id*DATA_W +: DATA_W];
        mem_we    <= we[win_id];
      end
      // Release happens whenever the owner drops lock, whether it is being accepted or idle.
      if (owner_valid) begin
        owner_valid <= lock[owner];
      end else if (accept && lock[win_id]) begin
        owner_valid <= 1'b1;
        owner       <= win_id;
      end
      if (ARB_MODE != 0 && accept && !owner_valid) begin
        ptr <= (win_id == LAST) ? '0 : win_id + 1'b1;
      end
      rd_vld[0] <= accept & ~we[win_id];
      rd_id[0]  <= win_id;
      for (int k = 1; k <= RD_LATENCY; k++) begin
        rd_vld[k] <= rd_vld[k-1];
        rd_id[k]  <= rd_id[k-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (rd_vld[RD_LATENCY]) rvalid[rd_id[RD_LATENCY]] = 1'b1;
    rdata = rd_vld[RD_LATENCY] ? mem_rdata : '0;
  end

`ifdef ARB_GRANT_COUNT_EN
  logic [NUM_MASTERS-1:0][15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept && cnt[win_id] != 16'hFFFF) begin
      cnt[win_id] <= cnt[win_id] + 16'd1;
    end
  end

  assign grant_count = cnt;
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share stimulus;
// reads on the fixed instance are tracked by a scoreboard queue.
module tb_mem_bus_arbiter;
  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;

  logic [N-1:0]    gnt_f, rvalid_f, gnt_r, rvalid_r;
  logic [DW-1:0]   rdata_f, mwd_f, mrd_f, rdata_r, mwd_r, mrd_r;
  logic [AW-1:0]   maddr_f, maddr_r;
  logic            mwe_f, mwe_r;
  logic [N*16-1:0] gc_f, gc_r;

  logic [AW-1:0]   dly_f [LAT];
  logic [AW-1:0]   dly_r [LAT];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           due;
    logic [N-1:0] id_oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .ARB_MODE(0))
  u_fix (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_f), .rvalid(rvalid_f), .rdata(rdata_f), .mem_addr(maddr_f), .mem_wdata(mwd_f),
    .mem_we(mwe_f), .mem_rdata(mrd_f), .grant_count(gc_f)
  );

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .ARB_MODE(1))
  u_rr (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_r), .rvalid(rvalid_r), .rdata(rdata_r), .mem_addr(maddr_r), .mem_wdata(mwd_r),
    .mem_we(mwe_r), .mem_rdata(mrd_r), .grant_count(gc_r)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h6D;
  endfunction

  // Memory model: data for the address presented LAT cycles earlier.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dly_f[0] <= maddr_f;
    dly_r[0] <= maddr_r;
    for (int k = 1; k < LAT; k++) begin
      dly_f[k] <= dly_f[k-1];
      dly_r[k] <= dly_r[k-1];
    end
  end
  assign mrd_f = mem_fn(dly_f[LAT-1]);
  assign mrd_r = mem_fn(dly_r[LAT-1]);

  // Read-return scoreboard for the fixed-priority instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (rvalid_f !== '0) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got rvalid=%b rdata=%h at cyc %0d, none expected",
                   rvalid_f, rdata_f, cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (rvalid_f !== mon_e.id_oh || rdata_f !== mon_e.data || cyc != mon_e.due) begin
            bad++;
            $display("FAIL rd_return: got rvalid=%b rdata=%h cyc=%0d, want %b %h cyc=%0d",
                     rvalid_f, rdata_f, cyc, mon_e.id_oh, mon_e.data, mon_e.due);
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL rd_missing: got no rvalid at cyc %0d, want %b data %h",
                 cyc, sbq[0].id_oh, sbq[0].data);
        void'(sbq.pop_front());
      end
    end
  end

  // Record an expected read return for a bench-predicted acceptance on the fixed instance.
  task automatic expect_acc(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i] && !we[i]) sbq.push_back('{cyc + 1 + LAT, g, mem_fn(addr[i*AW +: AW])});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; lock = '0; we = '0;
    sbq.delete();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    req = '0; lock = '0;
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; lock = '0; we = '0;
    sbq.delete();
    @(negedge clk);
    total += 10;
    if (gnt_f !== '0) begin bad++; $display("FAIL rst_gnt: got %b want 000", gnt_f); end
    if (gnt_r !== '0) begin bad++; $display("FAIL rst_gnt_rr: got %b want 000", gnt_r); end
    if (rvalid_f !== '0) begin bad++; $display("FAIL rst_rvalid: got %b want 000", rvalid_f); end
    if (rdata_f !== '0) begin bad++; $display("FAIL rst_rdata: got %h want 00", rdata_f); end
    if (maddr_f !== '0) begin bad++; $display("FAIL rst_maddr: got %h want 0000", maddr_f); end
    if (mwd_f !== '0) begin bad++; $display("FAIL rst_mwdata: got %h want 00", mwd_f); end
    if (mwe_f !== 1'b0) begin bad++; $display("FAIL rst_mwe: got %b want 0", mwe_f); end
    if (gc_f !== '0) begin bad++; $display("FAIL rst_gcount: got %h want 0", gc_f); end
    if (mwe_r !== 1'b0 || mwd_r !== '0) begin
      bad++; $display("FAIL rst_mem_rr: got we=%b wd=%h want 0 00", mwe_r, mwd_r);
    end
    if (rdata_r !== '0 || rvalid_r !== '0) begin
      bad++; $display("FAIL rst_rd_rr: got %b %h want 000 00", rvalid_r, rdata_r);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    req = 3'b111; we = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (gnt_f !== 3'b001) begin
        bad++; $display("FAIL fix_gnt%0d: got %b want 001", c, gnt_f);
      end
      if (c > 0) begin
        total++;
        if (maddr_f !== 16'h1010 || mwe_f !== 1'b0) begin
          bad++; $display("FAIL fix_maddr%0d: got %h we=%b want 1010 0", c, maddr_f, mwe_f);
        end
      end
      expect_acc(3'b001);
      next_cycle();
    end
    idle(LAT + 3);
  endtask

  task automatic test_rr();
    logic [N-1:0] exp_seq [9];
    logic [N-1:0] req_seq [9];
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    req_seq = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
    do_reset();
    we = 3'b111;
    for (int c = 0; c < 9; c++) begin
      req = req_seq[c];
      @(negedge clk);
      total++;
      if (gnt_r !== exp_seq[c]) begin
        bad++; $display("FAIL rr_gnt%0d: got %b want %b", c, gnt_r, exp_seq[c]);
      end
      total++;
      if (rvalid_r !== '0) begin
        bad++; $display("FAIL rr_wr_rvalid%0d: got %b want 000", c, rvalid_r);
      end
      next_cycle();
    end
    idle(LAT + 3);
  endtask

  task automatic test_read_latency();
    do_reset();
    addr[1*AW +: AW] = 16'hC800;
    idle(2);
    req = 3'b010; we = 3'b000;
    @(negedge clk);
    total++;
    if (gnt_f !== 3'b010) begin bad++; $display("FAIL lat_gnt: got %b want 010", gnt_f); end
    expect_acc(3'b010);
    next_cycle();
    req = '0;
    @(negedge clk);
    total += 2;
    if (maddr_f !== 16'hC800 || mwe_f !== 1'b0) begin
      bad++; $display("FAIL lat_maddr: got %h we=%b want C800 0", maddr_f, mwe_f);
    end
    if (rvalid_f !== '0) begin bad++; $display("FAIL lat_early1: got %b want 000", rvalid_f); end
    next_cycle();
    @(negedge clk);
    total++;
    if (rvalid_f !== '0) begin bad++; $display("FAIL lat_early2: got %b want 000", rvalid_f); end
    next_cycle();
    @(negedge clk);
    total++;
    if (rvalid_f !== 3'b010 || rdata_f !== 8'hA5) begin
      bad++; $display("FAIL lat_return: got %b %h want 010 A5", rvalid_f, rdata_f);
    end
    next_cycle();
    idle(2);
    addr[1*AW +: AW] = 16'h2020;
  endtask

  task automatic test_lock();
    logic [N-1:0] rq [10];
    logic [N-1:0] lk [10];
    logic [N-1:0] eg [10];
    rq = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b100, 3'b001, 3'b001, 3'b001};
    lk = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
    eg = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b000, 3'b000, 3'b001};
    do_reset();
    we = 3'b100;
    for (int c = 0; c < 10; c++) begin
      req = rq[c]; lock = lk[c];
      @(negedge clk);
      total++;
      if (gnt_f !== eg[c]) begin
        bad++; $display("FAIL lock_gnt%0d: got %b want %b", c, gnt_f, eg[c]);
      end
      if (c == 1) begin
        total++;
        if (mwe_f !== 1'b1 || maddr_f !== 16'h3030 || mwd_f !== 8'h33) begin
          bad++; $display("FAIL lock_write: got we=%b a=%h d=%h want 1 3030 33",
                          mwe_f, maddr_f, mwd_f);
        end
      end
      expect_acc(eg[c]);
      next_cycle();
    end
    req = '0; lock = '0;
    @(negedge clk);
    total++;
    if (mwe_f !== 1'b0 || maddr_f !== 16'h1010 || mwd_f !== 8'h11) begin
      bad++; $display("FAIL hold_mem: got we=%b a=%h d=%h want 0 1010 11", mwe_f, maddr_f, mwd_f);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (mwe_f !== 1'b0 || maddr_f !== 16'h1010) begin
      bad++; $display("FAIL hold_mem2: got we=%b a=%h want 0 1010", mwe_f, maddr_f);
    end
    next_cycle();
    idle(LAT + 3);
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] rq [3];
    rq = '{3'b001, 3'b010, 3'b001};
    do_reset();
    we = 3'b000;
    for (int c = 0; c < 3; c++) begin
      req = rq[c];
      @(negedge clk);
      total++;
      if (gnt_f !== rq[c]) begin
        bad++; $display("FAIL mid_gnt%0d: got %b want %b", c, gnt_f, rq[c]);
      end
      expect_acc(rq[c]);
      next_cycle();
    end
    reset = 1'b1;
    req = '0;
    sbq.delete();
    @(negedge clk);
    total++;
    if (rvalid_f !== '0 || rdata_f !== '0 || maddr_f !== '0 || mwe_f !== 1'b0 || gnt_f !== '0) begin
      bad++; $display("FAIL mid_rst: got rv=%b rd=%h a=%h we=%b g=%b want all zero",
                      rvalid_f, rdata_f, maddr_f, mwe_f, gnt_f);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      total++;
      if (rvalid_f !== '0 || rvalid_r !== '0) begin
        bad++; $display("FAIL mid_stale%0d: got %b %b want 000", c, rvalid_f, rvalid_r);
      end
      next_cycle();
    end
  endtask

  task automatic test_grant_count();
    do_reset();
`ifdef ARB_GRANT_COUNT_EN
    req = 3'b001; we = 3'b111;
    repeat (5) next_cycle();
    @(negedge clk);
    total++;
    if (gc_f[15:0] !== 16'd5) begin bad++; $display("FAIL gc_five: got %0d want 5", gc_f[15:0]); end
    repeat (70000) next_cycle();
    req = '0;
    @(negedge clk);
    total += 2;
    if (gc_f[15:0] !== 16'hFFFF) begin
      bad++; $display("FAIL gc_sat: got %h want FFFF", gc_f[15:0]);
    end
    if (gc_f[47:16] !== '0) begin
      bad++; $display("FAIL gc_others: got %h want 0", gc_f[47:16]);
    end
`else
    we = 3'b111;
    for (int c = 0; c < 6; c++) begin
      req = 3'b111;
      @(negedge clk);
      total++;
      if (gc_f !== '0 || gc_r !== '0) begin
        bad++; $display("FAIL gc_tied%0d: got %h %h want 0", c, gc_f, gc_r);
      end
      next_cycle();
    end
`endif
    idle(2);
  endtask

  initial begin
    reset = 1'b1;
    req = '0; lock = '0; we = '0;
    addr  = {16'h3030, 16'h2020, 16'h1010};
    wdata = {8'h33, 8'h22, 8'h11};
    #1;
    test_reset();
    test_fixed();
    test_rr();
    test_read_latency();
    test_lock();
    test_reset_midflight();
    test_grant_count();
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending reads want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
